proc_hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the TinyRV1 in-order processor, generalising the fixed five-stage controller. Tracks in-flight register writers over a configurable number of post-decode stages and generates bypass selects, load-use stalls, and branch/jump squashes. Provides W-stage register-file write control and saturating stall/squash performance counters. Sits between the decode logic, which supplies decoded source/destination fields, and the datapath, which consumes the select and enable signals.

---
 rtl/proc_hazard_ctrl_if.sv | 53 +++++
 rtl/proc_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_proc_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : proc_hazard_ctrl_if
// Purpose  : Decode/datapath-side signal bundle for the TinyRV1 hazard and
//            pipeline-control unit. The master modport is the decoder and
//            datapath, and the slave modport is proc_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface proc_hazard_ctrl_if #(
  parameter int NSTAGES = 3,
  parameter int AW      = 5,
  parameter int CNTW    = 32
);
  localparam int SELW = $clog2(NSTAGES + 1);

  // Decoded D-stage instruction fields
  logic            val_D;
  logic            rs1_en_D;
  logic            rs2_en_D;
  logic [AW-1:0]   rs1_D;
  logic [AW-1:0]   rs2_D;
  logic [AW-1:0]   rd_D;
  logic            wen_D;
  logic            load_D;
  logic            jump_D;
  logic            br_taken_X;

  // Pipeline control back to the datapath
  logic            reg_en_F;
  logic            reg_en_D;
  logic [1:0]      pc_sel_F;
  logic [SELW-1:0] op1_byp_sel_D;
  logic [SELW-1:0] op2_byp_sel_D;
  logic            rf_wen_W;
  logic [AW-1:0]   rf_waddr_W;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] squash_cnt;

  modport master (
    output val_D, rs1_en_D, rs2_en_D, rs1_D, rs2_D, rd_D,
           wen_D, load_D, jump_D, br_taken_X,
    input  reg_en_F, reg_en_D, pc_sel_F, op1_byp_sel_D, op2_byp_sel_D,
           rf_wen_W, rf_waddr_W, stall_cnt, squash_cnt
  );

  modport slave (
    input  val_D, rs1_en_D, rs2_en_D, rs1_D, rs2_D, rd_D,
           wen_D, load_D, jump_D, br_taken_X,
    output reg_en_F, reg_en_D, pc_sel_F, op1_byp_sel_D, op2_byp_sel_D,
           rf_wen_W, rf_waddr_W, stall_cnt, squash_cnt
  );
endinterface : proc_hazard_ctrl_if
`default_nettype wire

// File: rtl/proc_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : proc_hazard_ctrl
// Purpose  : Parametrised hazard / pipeline-control unit for TinyRV1.
//            Tracks in-flight register writers over NSTAGES post-decode
//            stages (1 = X ... NSTAGES = W). It generates bypass selects,
//            load-use stalls, and branch/jump squashes. It also drives the
//            W-stage register-file write and saturating stall/squash counters.
// Config   : PROC_HAZARD_BYPASS_EN - when defined, operands are forwarded from
//            the youngest matching stage. When undefined, D stalls on any
//            in-flight writer of a source register.
// Revision : 1.0 - initial release
// ============================================================================
module proc_hazard_ctrl #(
  parameter int NSTAGES    = 3,  // 2..6
  parameter int LOAD_STAGE = 2,  // 1..NSTAGES
  parameter int AW         = 5,
  parameter int CNTW       = 32
) (
  input  wire               clk,
  input  wire               rst,   // asynchronous, active low
  proc_hazard_ctrl_if.slave bus
);

  localparam int SELW = $clog2(NSTAGES + 1);

  // --------------------------------------------------------------------------
  // Per-stage tracking of in-flight instructions.
  // Index k is the post-decode stage number, so index 1 is X and index
  // NSTAGES is W.
  // --------------------------------------------------------------------------
  logic [NSTAGES:1] trk_val;
  logic [NSTAGES:1] trk_wen;
  logic [NSTAGES:1] trk_load;
  logic [AW-1:0]    trk_rd [1:NSTAGES];

  logic [NSTAGES:1] match1;
  logic [NSTAGES:1] match2;
  logic [SELW-1:0]  sel1;
  logic [SELW-1:0]  sel2;
  logic             load_stall;
  logic             raw_stall;
  logic             squash_D;
  logic             stall;
  logic             jump_go;
  logic             squash_F;
  logic             issue;
  logic [1:0]       pc_sel;
  logic             rf_wen;

  logic [CNTW-1:0]  stall_cnt_r;
  logic [CNTW-1:0]  squash_cnt_r;

  // --------------------------------------------------------------------------
  // Source matching. A stage matches when it holds a valid writer of a
  // non-zero register that the D instruction actually reads. x0 never matches.
  // --------------------------------------------------------------------------

  // Compare each tracked destination against both D sources.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 1; k <= NSTAGES; k++) begin
      match1[k] = bus.rs1_en_D & bus.val_D & trk_val[k] & trk_wen[k] &
                  (trk_rd[k] == bus.rs1_D) & (trk_rd[k] != '0);
      match2[k] = bus.rs2_en_D & bus.val_D & trk_val[k] & trk_wen[k] &
                  (trk_rd[k] == bus.rs2_D) & (trk_rd[k] != '0);
    end
  end

  // Bypass selects: the youngest (lowest-numbered) matching stage wins.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
`ifdef PROC_HAZARD_BYPASS_EN
    for (int k = NSTAGES; k >= 1; k--) begin
      if (match1[k]) sel1 = SELW'(k);
      if (match2[k]) sel2 = SELW'(k);
    end
`endif
  end

  // Load-use detection: a matching load has no data on the bypass network
  // until it reaches LOAD_STAGE.
  always_comb begin
    load_stall = 1'b0;
    for (int k = 1; k <= NSTAGES; k++) begin
      if ((match1[k] | match2[k]) && trk_load[k] && (k < LOAD_STAGE))
        load_stall = 1'b1;
    end
  end

  // Stall source selection. Without forwarding, any in-flight writer of a
  // source blocks D until it has left W. That rule already covers loads.
`ifdef PROC_HAZARD_BYPASS_EN
  assign raw_stall = load_stall;
`else
  assign raw_stall = (|match1) | (|match2) | load_stall;
`endif

  // --------------------------------------------------------------------------
  // Control-flow priority: a taken branch in X beats a stall, and a stall
  // beats a jump in D. A jump held in a stall is simply retried on the next
  // cycle. The jump term is gated by rst so that pc_sel_F stays 0 during
  // reset. The other terms are already quiet then because the tracking
  // state is cleared.
  // --------------------------------------------------------------------------
  assign squash_D = trk_val[1] & bus.br_taken_X;
  assign stall    = raw_stall & ~squash_D;
  assign jump_go  = bus.val_D & bus.jump_D & ~stall & rst;
  assign squash_F = squash_D | jump_go;
  assign issue    = bus.val_D & ~stall & ~squash_D;

  // PC select for the next fetch.
  always_comb begin
    pc_sel = 2'd0;
    if (squash_D)     pc_sel = 2'd2;
    else if (stall)   pc_sel = 2'd0;
    else if (jump_go) pc_sel = 2'd1;
  end

  // --------------------------------------------------------------------------
  // Tracking pipeline. Stage 1 takes the D fields only when D actually issues.
  // Otherwise it takes a bubble. The other stages shift down unconditionally
  // because the datapath stage enables are always on.
  // --------------------------------------------------------------------------

  // Advance the tracking registers one stage per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_val  <= '0;
      trk_wen  <= '0;
      trk_load <= '0;
      for (int k = 1; k <= NSTAGES; k++) trk_rd[k] <= '0;
    end else begin
      trk_val[1]  <= issue;
      trk_wen[1]  <= bus.wen_D;
      trk_load[1] <= bus.load_D;
      trk_rd[1]   <= bus.rd_D;
      for (int k = 2; k <= NSTAGES; k++) begin
        trk_val[k]  <= trk_val[k-1];
        trk_wen[k]  <= trk_wen[k-1];
        trk_load[k] <= trk_load[k-1];
        trk_rd[k]   <= trk_rd[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // W-stage register-file write. The address is forced to 0 when no write
  // happens so that the RF port sees a clean value.
  // --------------------------------------------------------------------------
  assign rf_wen = trk_val[NSTAGES] & trk_wen[NSTAGES] & (trk_rd[NSTAGES] != '0);

  // --------------------------------------------------------------------------
  // Performance counters. They count effective stalls and F squashes, and
  // they stick at all-ones.
  // --------------------------------------------------------------------------

  // Saturating event counters, updated on the edge after the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r  <= '0;
      squash_cnt_r <= '0;
    end else begin
      if (stall && (stall_cnt_r != '1))
        stall_cnt_r <= stall_cnt_r + CNTW'(1);
      if (squash_F && (squash_cnt_r != '1))
        squash_cnt_r <= squash_cnt_r + CNTW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.reg_en_F      = ~stall;
  assign bus.reg_en_D      = ~stall;
  assign bus.pc_sel_F      = pc_sel;
  assign bus.op1_byp_sel_D = sel1;
  assign bus.op2_byp_sel_D = sel2;
  assign bus.rf_wen_W      = rf_wen;
  assign bus.rf_waddr_W    = rf_wen ? trk_rd[NSTAGES] : '0;
  assign bus.stall_cnt     = stall_cnt_r;
  assign bus.squash_cnt    = squash_cnt_r;

endmodule : proc_hazard_ctrl
`default_nettype wire

// File: tb/tb_proc_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_hazard_ctrl
// Purpose  : Directed self-checking bench for proc_hazard_ctrl with
//            NSTAGES=3, LOAD_STAGE=2, AW=5, CNTW=4 (narrow counters so that
//            saturation is reachable). Expectations follow the
//            PROC_HAZARD_BYPASS_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_proc_hazard_ctrl;
  localparam int NST = 3;

`ifdef PROC_HAZARD_BYPASS_EN
  localparam int STALL_LU = 1;   // load-use stall cycles, load one stage ahead
`else
  localparam int STALL_LU = 3;   // any writer stalls until it leaves W
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] exp_stall  = '0;
  logic [3:0] exp_squash = '0;

  proc_hazard_ctrl_if #(.NSTAGES(NST), .AW(5), .CNTW(4)) bus ();

  proc_hazard_ctrl #(.NSTAGES(NST), .LOAD_STAGE(2), .AW(5), .CNTW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ctl = {reg_en_F, reg_en_D, pc_sel_F, op1_sel, op2_sel}; rfw = {wen, waddr}
  wire [7:0] ctl = {bus.reg_en_F, bus.reg_en_D, bus.pc_sel_F,
                    bus.op1_byp_sel_D, bus.op2_byp_sel_D};
  wire [5:0] rfw = {bus.rf_wen_W, bus.rf_waddr_W};

  task automatic tick();   @(posedge clk); #1; endtask
  task automatic settle(); #3;                 endtask

  task automatic d_nop();
    bus.val_D = 0; bus.rs1_en_D = 0; bus.rs2_en_D = 0; bus.rs1_D = 0;
    bus.rs2_D = 0; bus.rd_D = 0; bus.wen_D = 0; bus.load_D = 0;
    bus.jump_D = 0; bus.br_taken_X = 0;
  endtask

  task automatic d_ins(input logic r1e, input logic [4:0] r1, input logic r2e,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic jmp);
    bus.val_D = 1; bus.rs1_en_D = r1e; bus.rs1_D = r1; bus.rs2_en_D = r2e;
    bus.rs2_D = r2; bus.rd_D = rd; bus.wen_D = wen; bus.load_D = ld;
    bus.jump_D = jmp; bus.br_taken_X = 0;
  endtask

  task automatic bump_stall();  if (exp_stall  != 4'hF) exp_stall++;  endtask
  task automatic bump_squash(); if (exp_squash != 4'hF) exp_squash++; endtask

  task automatic flush(); d_nop(); repeat (NST) tick(); endtask

  task automatic test_reset();
    rst = 1'b0;
    d_ins(0, 0, 0, 0, 1, 1, 0, 1);     // JAL x1 held during reset
    settle();
    checks++; if (ctl !== 8'hC0) begin errors++; $display("FAIL reset_ctl: got %h want c0", ctl); end
    checks++; if (rfw !== 6'h00) begin errors++; $display("FAIL reset_rf: got %h want 00", rfw); end
    checks++; if ({bus.stall_cnt, bus.squash_cnt} !== 8'h00) begin errors++;
      $display("FAIL reset_cnt: got %h want 00", {bus.stall_cnt, bus.squash_cnt}); end
    d_nop();
    @(negedge clk); rst = 1'b1;
    tick(); settle();
    checks++; if (ctl !== 8'hC0 || rfw !== 6'h00) begin errors++;
      $display("FAIL reset_first: got %h/%h want c0/00", ctl, rfw); end
    tick();
  endtask

  task automatic test_bypass();
    d_ins(1, 0, 0, 0, 1, 1, 0, 0);     // ADDI x1
    settle();
    checks++; if (ctl !== 8'hC0) begin errors++; $display("FAIL byp_first: got %h want c0", ctl); end
    tick();
    d_ins(1, 1, 1, 1, 2, 1, 0, 0);     // ADD x2,x1,x1
    settle();
`ifdef PROC_HAZARD_BYPASS_EN
    checks++; if (ctl !== 8'hC5) begin errors++; $display("FAIL byp_x: got %h want c5", ctl); end
    tick(); flush();
    d_ins(1, 0, 0, 0, 1, 1, 0, 0); tick();   // ADDI x1
    d_ins(1, 0, 0, 0, 1, 1, 0, 0); tick();   // ADDI x1
    d_nop(); tick();
    d_ins(1, 1, 1, 1, 2, 1, 0, 0); settle(); // x1 now at stages 2 and 3
    checks++; if (ctl !== 8'hCA) begin errors++; $display("FAIL byp_youngest: got %h want ca", ctl); end
    tick();
`else
    for (int c = 0; c < 3; c++) begin
      checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL nobyp_stall%0d: got %h want 00", c, ctl); end
      if (c == 2) begin
        checks++; if (rfw !== 6'h21) begin errors++; $display("FAIL nobyp_w: got %h want 21", rfw); end
      end
      bump_stall(); tick(); settle();
    end
    checks++; if (ctl !== 8'hC0) begin errors++; $display("FAIL nobyp_issue: got %h want c0", ctl); end
    tick();
`endif
    flush(); settle();
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++;
      $display("FAIL byp_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
    tick();
  endtask

  task automatic test_load_use();
    d_ins(1, 0, 0, 0, 3, 1, 1, 0); tick();   // LW x3
    d_ins(1, 3, 1, 0, 4, 1, 0, 0); settle(); // ADD x4,x3,x0
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL lu_stall: got %h want 00", ctl); end
    bump_stall(); tick(); settle();
`ifdef PROC_HAZARD_BYPASS_EN
    checks++; if (ctl !== 8'hC8) begin errors++; $display("FAIL lu_byp: got %h want c8", ctl); end
    tick(); d_nop(); settle();
    checks++; if (rfw !== 6'h23) begin errors++; $display("FAIL lu_w_lw: got %h want 23", rfw); end
    tick(); settle();
    checks++; if (rfw !== 6'h00) begin errors++; $display("FAIL lu_w_bubble: got %h want 00", rfw); end
    tick(); settle();
`else
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL lu_stall2: got %h want 00", ctl); end
    bump_stall(); tick(); settle();
    checks++; if (rfw !== 6'h23) begin errors++; $display("FAIL lu_w_lw: got %h want 23", rfw); end
    bump_stall(); tick(); settle();
    checks++; if (ctl !== 8'hC0 || rfw !== 6'h00) begin errors++;
      $display("FAIL lu_issue: got %h/%h want c0/00", ctl, rfw); end
    tick(); d_nop(); tick(); tick(); settle();
`endif
    checks++; if (rfw !== 6'h24) begin errors++; $display("FAIL lu_w_add: got %h want 24", rfw); end
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++;
      $display("FAIL lu_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
    tick(); flush();
  endtask

  task automatic test_x0();
    d_ins(1, 0, 0, 0, 0, 1, 0, 0); tick();   // ADDI x0
    d_ins(1, 0, 1, 0, 5, 1, 0, 0); settle(); // ADD x5,x0,x0
    checks++; if (ctl !== 8'hC0) begin errors++; $display("FAIL x0_ctl: got %h want c0", ctl); end
    tick(); d_nop(); tick(); settle();
    checks++; if (rfw !== 6'h00) begin errors++; $display("FAIL x0_w: got %h want 00", rfw); end
    tick(); settle();
    checks++; if (rfw !== 6'h25) begin errors++; $display("FAIL x0_w_next: got %h want 25", rfw); end
    tick(); flush();
  endtask

  task automatic test_branch_squash();
    d_ins(1, 0, 0, 0, 5, 1, 1, 0); tick();   // LW x5
    d_ins(1, 5, 1, 5, 6, 1, 0, 0);           // ADD x6,x5,x5 (load-use)
    bus.br_taken_X = 1'b1; settle();
    checks++; if (ctl[7:4] !== 4'hE) begin errors++; $display("FAIL br_ctl: got %h want e", ctl[7:4]); end
    bump_squash(); tick(); d_nop(); settle();
    checks++; if ({bus.stall_cnt, bus.squash_cnt} !== {exp_stall, exp_squash}) begin errors++;
      $display("FAIL br_cnt: got %h want %h", {bus.stall_cnt, bus.squash_cnt}, {exp_stall, exp_squash}); end
    tick(); settle();
    checks++; if (rfw !== 6'h25) begin errors++; $display("FAIL br_w_lw: got %h want 25", rfw); end
    tick(); settle();
    checks++; if (rfw !== 6'h00) begin errors++; $display("FAIL br_w_add: got %h want 00", rfw); end
    tick(); flush();
  endtask

  task automatic test_jump();
    d_ins(0, 0, 0, 0, 1, 1, 0, 1); settle(); // JAL x1
    checks++; if (ctl !== 8'hD0) begin errors++; $display("FAIL jal_ctl: got %h want d0", ctl); end
    bump_squash(); tick(); flush();
    d_ins(1, 0, 0, 0, 7, 1, 1, 0); tick();   // LW x7
    d_ins(1, 7, 0, 0, 0, 0, 0, 1); settle(); // JR x7
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL jr_defer: got %h want 00", ctl); end
    bump_stall(); tick(); settle();
`ifdef PROC_HAZARD_BYPASS_EN
    checks++; if (ctl !== 8'hD8) begin errors++; $display("FAIL jr_go: got %h want d8", ctl); end
`else
    for (int c = 0; c < 2; c++) begin
      checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL jr_defer%0d: got %h want 00", c, ctl); end
      bump_stall(); tick(); settle();
    end
    checks++; if (ctl !== 8'hD0) begin errors++; $display("FAIL jr_go: got %h want d0", ctl); end
`endif
    bump_squash(); tick(); d_nop(); settle();
    checks++; if ({bus.stall_cnt, bus.squash_cnt} !== {exp_stall, exp_squash}) begin errors++;
      $display("FAIL jump_cnt: got %h want %h", {bus.stall_cnt, bus.squash_cnt}, {exp_stall, exp_squash}); end
    tick(); flush();
  endtask

  task automatic test_reset_mid_stall();
    d_ins(1, 0, 0, 0, 3, 1, 1, 0); tick();   // LW x3
    d_ins(1, 3, 0, 0, 4, 1, 0, 0); settle(); // ADD x4,x3
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL rms_pre: got %h want 00", ctl); end
    rst = 1'b0; #2;
    exp_stall = '0; exp_squash = '0;
    checks++; if (ctl !== 8'hC0 || rfw !== 6'h00) begin errors++;
      $display("FAIL rms_out: got %h/%h want c0/00", ctl, rfw); end
    checks++; if ({bus.stall_cnt, bus.squash_cnt} !== 8'h00) begin errors++;
      $display("FAIL rms_cnt: got %h want 00", {bus.stall_cnt, bus.squash_cnt}); end
    rst = 1'b1;
    tick(); settle();
    checks++; if (ctl !== 8'hC0 || rfw !== 6'h00) begin errors++;
      $display("FAIL rms_first: got %h/%h want c0/00", ctl, rfw); end
    tick(); flush();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 18; i++) begin
      d_ins(0, 0, 0, 0, 0, 0, 0, 1);         // back-to-back jumps
      bump_squash(); tick();
    end
    for (int p = 0; p < 16; p++) begin
      d_ins(1, 0, 0, 0, 3, 1, 1, 0); tick(); // LW x3
      d_ins(1, 3, 0, 0, 4, 1, 0, 0);         // ADD x4,x3
      repeat (STALL_LU) begin bump_stall(); tick(); end
      tick();
    end
    d_nop(); settle();
    checks++; if (bus.squash_cnt !== exp_squash || exp_squash !== 4'hF) begin errors++;
      $display("FAIL sat_squash: got %h want f", bus.squash_cnt); end
    checks++; if (bus.stall_cnt !== exp_stall || exp_stall !== 4'hF) begin errors++;
      $display("FAIL sat_stall: got %h want f", bus.stall_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_x0();
    test_branch_squash();
    test_jump();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule : tb_proc_hazard_ctrl
`default_nettype wire
